// File: rtl/multicycle_ctrl_pkg.sv
// ============================================================================
// Module  : multicycle_pkg
// Brief   : States, opcodes and datapath select encodings for multicycle_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

package multicycle_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_ALUWB  = 4'd4,
    S_ADDR   = 4'd5,
    S_MEMRD  = 4'd6,
    S_MEMWB  = 4'd7,
    S_MEMWR  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  localparam logic [1:0] ALUB_B     = 2'd0;
  localparam logic [1:0] ALUB_FOUR  = 2'd1;
  localparam logic [1:0] ALUB_IMM   = 2'd2;
  localparam logic [1:0] ALUB_IMMSH = 2'd3;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  function automatic logic is_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
// ============================================================================
// Module  : multicycle_ctrl_if
// Brief   : Controller <-> datapath/memory signal bundle. The master modport
//           is the controller. Macro MULTICYCLE_CTRL_PERF_CNT_EN adds instr_cnt.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface multicycle_ctrl_if
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  #(parameter int CNT_W = 32)
`endif
  ;
  logic       en;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ack;
  logic       pc_we;
  logic       ir_we;
  logic       ab_we;
  logic       aluout_we;
  logic       mdr_we;
  logic       rf_we;
  logic       mem_req;
  logic       mem_wr;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       rf_dst;
  logic       rf_src;
  logic       illegal;
  logic [3:0] state;
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] instr_cnt;
`endif

  modport master (
    input  en, opcode, zero, mem_ack,
    output pc_we, ir_we, ab_we, aluout_we, mdr_we, rf_we, mem_req, mem_wr,
           pc_src, alu_src_a, alu_src_b, alu_op, rf_dst, rf_src, illegal, state
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    , output instr_cnt
`endif
  );

  modport slave (
    output en, opcode, zero, mem_ack,
    input  pc_we, ir_we, ab_we, aluout_we, mdr_we, rf_we, mem_req, mem_wr,
           pc_src, alu_src_a, alu_src_b, alu_op, rf_dst, rf_src, illegal, state
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    , input instr_cnt
`endif
  );

endinterface

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module  : multicycle_ctrl
// Brief   : Moore control FSM for the multicycle MIPS-style datapath.
//           Macro MULTICYCLE_CTRL_PERF_CNT_EN adds a retired-instruction counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_ctrl
  import multicycle_pkg::*;
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  #(parameter int CNT_W = 32)
`endif
(
  input  wire               clk,
  input  wire               rst_n,
  multicycle_ctrl_if.master bus
);

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.pc_we     = 1'b0;
    bus.ir_we     = 1'b0;
    bus.ab_we     = 1'b0;
    bus.aluout_we = 1'b0;
    bus.mdr_we    = 1'b0;
    bus.rf_we     = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.pc_src    = PCSRC_ALU;
    bus.alu_src_a = 1'b0;
    bus.alu_src_b = ALUB_B;
    bus.alu_op    = ALUOP_ADD;
    bus.rf_dst    = 1'b0;
    bus.rf_src    = 1'b0;
    bus.illegal   = 1'b0;

    case (state_q)
      S_IDLE: if (bus.en) state_d = S_FETCH;
      S_FETCH: begin
        bus.mem_req   = 1'b1;
        bus.alu_src_b = ALUB_FOUR;
        if (bus.mem_ack) begin
          bus.ir_we = 1'b1;
          bus.pc_we = 1'b1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        bus.alu_src_b = ALUB_IMMSH;
        // An undefined opcode loads nothing beyond what fetch already wrote
        if (is_legal(bus.opcode)) begin
          bus.ab_we     = 1'b1;
          bus.aluout_we = 1'b1;
        end
        case (bus.opcode)
          OP_RTYPE, OP_ADDI: state_d = S_EXEC;
          OP_LW, OP_SW:      state_d = S_ADDR;
          OP_BEQ:            state_d = S_BRANCH;
          OP_J:              state_d = S_JUMP;
          default: begin
            bus.illegal = 1'b1;
            state_d     = S_IDLE;
          end
        endcase
      end
      S_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.aluout_we = 1'b1;
        if (bus.opcode == OP_RTYPE) begin
          bus.alu_src_b = ALUB_B;
          bus.alu_op    = ALUOP_FUNCT;
        end else begin
          bus.alu_src_b = ALUB_IMM;
          bus.alu_op    = ALUOP_ADD;
        end
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        bus.rf_we  = 1'b1;
        bus.rf_dst = (bus.opcode == OP_RTYPE);
        state_d    = S_IDLE;
      end
      S_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = ALUB_IMM;
        bus.aluout_we = 1'b1;
        state_d       = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ack) begin
          bus.mdr_we = 1'b1;
          state_d    = S_MEMWB;
        end
      end
      S_MEMWB: begin
        bus.rf_we  = 1'b1;
        bus.rf_src = 1'b1;
        state_d    = S_IDLE;
      end
      S_MEMWR: begin
        bus.mem_req = 1'b1;
        bus.mem_wr  = 1'b1;
        if (bus.mem_ack) state_d = S_IDLE;
      end
      S_BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = ALUB_B;
        bus.alu_op    = ALUOP_SUB;
        bus.pc_src    = PCSRC_ALUOUT;
        bus.pc_we     = bus.zero;
        state_d       = S_IDLE;
      end
      S_JUMP: begin
        bus.pc_src = PCSRC_JUMP;
        bus.pc_we  = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.state = state_q;

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  logic             retire;
  logic [CNT_W-1:0] cnt_q;

  // Only the final state of each legal instruction counts; the illegal exit is from S_DECODE
  assign retire = (state_q == S_ALUWB) || (state_q == S_MEMWB) ||
                  (state_q == S_BRANCH) || (state_q == S_JUMP) ||
                  ((state_q == S_MEMWR) && bus.mem_ack);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt_q <= '0;
    else if (retire) cnt_q <= cnt_q + 1'b1;
  end

  assign bus.instr_cnt = cnt_q;
`endif

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore control FSM that sequences the 32-bit write-enabled datapath registers (PC, IR, A/B, ALUOut, MDR) and the register file of the multicycle MIPS-style core.
- Decodes IR opcode and ALU Zero flag.
- Drives every register WE, datapath mux selects and a req/ack memory handshake.
- Sits beside the datapath top-level; one instance per core.

Parameters:
- CNT_W, 32, width of the retired-instruction counter (used only with the optional feature).

Ports:
- CLK  in  1  system clock, all state on posedge.
- RST_N  in  1  asynchronous active-low reset.
- EN  in  1  run enable; sampled only in S_IDLE.
- OPCODE  in  6  IR[31:26].
- ZERO  in  1  ALU zero flag.
- MEM_ACK  in  1  memory completes the pending request this cycle.
- PC_WE, IR_WE, AB_WE, ALUOUT_WE, MDR_WE, RF_WE  out  1 each  register write enables.
- MEM_REQ  out  1  memory request, held until MEM_ACK.
- MEM_WR  out  1  request is a write (valid with MEM_REQ).
- PC_SRC  out  2  0=ALU result (PC+4), 1=ALUOut (branch target), 2=jump address.
- ALU_SRC_A  out  1  0=PC, 1=A.
- ALU_SRC_B  out  2  0=B, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2.
- ALU_OP  out  2  0=add, 1=sub, 2=funct-decoded.
- RF_DST  out  1  0=rt, 1=rd.
- RF_SRC  out  1  0=ALUOut, 1=MDR.
- ILLEGAL  out  1  one-cycle pulse on an undefined opcode.
- STATE  out  4  current state encoding (debug).

Behaviour:
- Reset (async, RST_N=0):
  - State is S_IDLE (4'd0).
  - All WE, MEM_REQ, MEM_WR and ILLEGAL are 0; all selects are 0.
  - Asserting reset mid-operation drops MEM_REQ immediately. The abandoned access is discarded.
- Outputs are a combinational decode of the state register. Enables that depend on MEM_ACK or ZERO are ANDed with those inputs in the same cycle.
- Unlisted outputs in each state are 0.
- Opcodes: RTYPE=000000, LW=100011, SW=101011, BEQ=000100, ADDI=001000, J=000010.
- S_IDLE: no outputs. EN=1 -> S_FETCH, else stay.
- S_FETCH:
  - MEM_REQ=1, ALU_SRC_A=0, ALU_SRC_B=1, PC_SRC=0.
  - On MEM_ACK: IR_WE=1, PC_WE=1, next S_DECODE. Otherwise stay; the request is held.
- S_DECODE:
  - AB_WE=1, ALUOUT_WE=1, ALU_SRC_A=0, ALU_SRC_B=3 (precomputes the branch target).
  - Next state by opcode: RTYPE/ADDI -> S_EXEC; LW/SW -> S_ADDR; BEQ -> S_BRANCH; J -> S_JUMP.
  - Any other opcode: ILLEGAL=1, next S_IDLE.
- S_EXEC:
  - ALU_SRC_A=1, ALUOUT_WE=1.
  - RTYPE: ALU_SRC_B=0, ALU_OP=2. ADDI: ALU_SRC_B=2, ALU_OP=0.
  - Next S_ALUWB.
- S_ALUWB: RF_WE=1, RF_SRC=0. RF_DST=1 for RTYPE, 0 for ADDI. Next S_IDLE.
- S_ADDR: ALU_SRC_A=1, ALU_SRC_B=2, ALU_OP=0, ALUOUT_WE=1. Next S_MEMRD (LW) or S_MEMWR (SW).
- S_MEMRD: MEM_REQ=1. On MEM_ACK: MDR_WE=1, next S_MEMWB. Otherwise stay.
- S_MEMWB: RF_WE=1, RF_SRC=1, RF_DST=0. Next S_IDLE.
- S_MEMWR: MEM_REQ=1, MEM_WR=1. On MEM_ACK -> S_IDLE. Otherwise stay.
- S_BRANCH: ALU_SRC_A=1, ALU_SRC_B=0, ALU_OP=1, PC_SRC=1, PC_WE=ZERO. Next S_IDLE.
- S_JUMP: PC_SRC=2, PC_WE=1. Next S_IDLE.
- The opcode is decoded from the registered IR, so OPCODE is stable from S_DECODE onward. The FSM uses it in S_DECODE and in the later states.
- Latency with zero-wait memory (MEM_ACK in the same cycle as MEM_REQ), counted from S_IDLE with EN=1, including the S_IDLE cycle:

  | Instruction   | Cycles |
  |---------------|--------|
  | RTYPE / ADDI  | 5      |
  | LW            | 6      |
  | SW            | 5      |
  | BEQ / J       | 4      |

  Each memory wait cycle adds 1.
- MEM_ACK arriving when MEM_REQ=0 is ignored.
- EN deasserted mid-instruction does not abort; the instruction completes and the FSM parks in S_IDLE.

Optional Feature:
- Macro: MULTICYCLE_CTRL_PERF_CNT_EN.
- Defined:
  - Adds output INSTR_CNT [CNT_W-1:0].
  - Increments on every transition into S_IDLE from a completing state; the ILLEGAL path does not count.
  - Reset value 0; wraps at all-ones -> 0.
- Undefined: the port and the counter logic are absent. FSM behaviour is identical.

Decomposition:
- Package multicycle_pkg holds:
  - the state enumeration (4-bit);
  - the opcode constants;
  - the PC_SRC, ALU_SRC_B and ALU_OP encodings.
- No sub-module. The FSM state register and the output decode stay in one module.

Test Plan:
- Reset: RST_N=0 with the FSM in S_MEMRD and MEM_REQ=1 -> MEM_REQ=0 and STATE=0 within the same cycle. After release with EN=0, STATE stays 0 for 10 cycles.
- R-type: EN=1, OPCODE=000000, MEM_ACK tied 1:
  - expect IR_WE+PC_WE in cycle 2, AB_WE in cycle 3, ALUOUT_WE with ALU_OP=2 in cycle 4;
  - RF_WE with RF_DST=1 in cycle 5, then STATE=0.
- LW with 3 wait cycles on data access (OPCODE=100011, MEM_ACK low for 3 cycles in S_MEMRD) -> MEM_REQ held 4 cycles, MDR_WE only in the ack cycle, then RF_WE with RF_SRC=1.
- SW: OPCODE=101011 -> MEM_REQ=1 and MEM_WR=1 in S_MEMWR, no RF_WE pulse anywhere.
- BEQ: ZERO=1 -> PC_WE=1 with PC_SRC=1. ZERO=0 -> PC_WE=0 in S_BRANCH.
- Illegal opcode 111111 -> ILLEGAL single-cycle pulse in S_DECODE, no WE other than the fetch ones. With MULTICYCLE_CTRL_PERF_CNT_EN, INSTR_CNT stays unchanged, while 3 legal instructions give INSTR_CNT=3.
